// File: rtl/nubus_pkg.sv
// Shared types and constants for the NuBus slave responder.
package nubus_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WDATA   = 2'd1,
        S_ACCESS  = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    // Status codes as driven on {TM1,TM0}, asserted-high.
    localparam logic [1:0] ST_COMPLETE  = 2'b00;
    localparam logic [1:0] ST_ERROR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT   = 2'b10;
    localparam logic [1:0] ST_TRY_AGAIN = 2'b11;

    // Size codes formed as {TM0, AD[1:0]} at START.
    localparam logic [2:0] SZ_BYTE0 = 3'b000;
    localparam logic [2:0] SZ_BYTE1 = 3'b001;
    localparam logic [2:0] SZ_BYTE2 = 3'b010;
    localparam logic [2:0] SZ_BYTE3 = 3'b011;
    localparam logic [2:0] SZ_HALF0 = 3'b100;
    localparam logic [2:0] SZ_BLOCK = 3'b101;
    localparam logic [2:0] SZ_HALF1 = 3'b110;
    localparam logic [2:0] SZ_WORD  = 3'b111;

    // Byte-lane enables for a size code; block mode enables no lanes.
    function automatic logic [3:0] sel_from_size(input logic [2:0] code);
        logic [3:0] sel;
        case (code)
            SZ_BYTE0: sel = 4'b0001;
            SZ_BYTE1: sel = 4'b0010;
            SZ_BYTE2: sel = 4'b0100;
            SZ_BYTE3: sel = 4'b1000;
            SZ_HALF0: sel = 4'b0011;
            SZ_HALF1: sel = 4'b1100;
            SZ_WORD:  sel = 4'b1111;
            default:  sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/nubus_mode_decode.sv
// Combinational decode of NuBus transfer mode into direction and byte lanes.
module nubus_mode_decode
    import nubus_pkg::*;
(
    input  logic [1:0] tm_in,
    input  logic [1:0] ad_lo,
    output logic       we,
    output logic [3:0] sel,
    output logic       is_block
);

    logic [2:0] code;

    // TM1 gives direction; {TM0, AD[1:0]} gives the transfer size.
    always_comb begin
        code     = {tm_in[0], ad_lo};
        we       = tm_in[1];
        sel      = sel_from_size(code);
        is_block = (code == SZ_BLOCK);
    end

endmodule

// File: rtl/nubus_slave_responder.sv
// NuBus slave transaction engine: START decode, one local-bus access, single-cycle ACK.
module nubus_slave_responder
    import nubus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int LB_ADDR_W      = 22
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [3:0]           slot_id,
    input  logic                 start,
    input  logic                 ack_in,
    input  logic [31:0]          ad_in,
    input  logic [1:0]           tm_in,
    output logic [31:0]          ad_out,
    output logic                 ad_oe,
    output logic [1:0]           tm_out,
    output logic                 ack_out,
    output logic                 resp_oe,
    output logic                 lb_cyc,
    output logic                 lb_we,
    output logic [LB_ADDR_W-1:0] lb_adr,
    output logic [3:0]           lb_sel,
    output logic [31:0]          lb_dat_w,
    input  logic [31:0]          lb_dat_r,
    input  logic                 lb_ack,
    input  logic                 lb_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 lb_cyc_q, lb_cyc_d;
    logic                 lb_we_q, lb_we_d;
    logic [LB_ADDR_W-1:0] lb_adr_q, lb_adr_d;
    logic [3:0]           lb_sel_q, lb_sel_d;
    logic [31:0]          lb_dat_w_q, lb_dat_w_d;
    logic [31:0]          ad_out_q, ad_out_d;
    logic                 ad_oe_q, ad_oe_d;
    logic [1:0]           tm_out_q, tm_out_d;
    logic                 ack_out_q, ack_out_d;
    logic                 resp_oe_q, resp_oe_d;

    logic                 dec_we;
    logic [3:0]           dec_sel;
    logic                 dec_block;
    logic                 match;

    nubus_mode_decode u_mode_decode (
        .tm_in    (tm_in),
        .ad_lo    (ad_in[1:0]),
        .we       (dec_we),
        .sel      (dec_sel),
        .is_block (dec_block)
    );

    // A START addressed to our slot space; attention cycles (ACK also high) excluded.
    always_comb begin
        match = start && !ack_in && (ad_in[31:28] == 4'hF) && (ad_in[27:24] == slot_id);
    end

    // Next-state and registered-output computation; outputs only live in their own states.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lb_cyc_d   = 1'b0;
        lb_we_d    = lb_we_q;
        lb_adr_d   = lb_adr_q;
        lb_sel_d   = lb_sel_q;
        lb_dat_w_d = lb_dat_w_q;
        ad_out_d   = ad_out_q;
        ad_oe_d    = 1'b0;
        tm_out_d   = ST_COMPLETE;
        ack_out_d  = 1'b0;
        resp_oe_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (match) begin
                    if (dec_block) begin
                        state_d   = S_RESPOND;
                        resp_oe_d = 1'b1;
                        ack_out_d = 1'b1;
                        tm_out_d  = ST_ERROR;
                    end else begin
                        lb_adr_d = ad_in[LB_ADDR_W+1:2];
                        lb_sel_d = dec_sel;
                        lb_we_d  = dec_we;
                        if (dec_we) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d  = S_ACCESS;
                            lb_cyc_d = 1'b1;
                        end
                    end
                end
            end
            S_WDATA: begin
                lb_dat_w_d = ad_in;
                state_d    = S_ACCESS;
                lb_cyc_d   = 1'b1;
            end
            S_ACCESS: begin
                if (lb_err || lb_ack || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d   = S_RESPOND;
                    resp_oe_d = 1'b1;
                    ack_out_d = 1'b1;
                    cnt_d     = '0;
                    if (lb_err) begin
                        tm_out_d = ST_ERROR;
                    end else if (lb_ack) begin
                        tm_out_d = ST_COMPLETE;
                        if (!lb_we_q) begin
                            ad_out_d = lb_dat_r;
                            ad_oe_d  = 1'b1;
                        end
                    end else begin
                        tm_out_d = ST_TIMEOUT;
                    end
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    lb_cyc_d = 1'b1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears everything so nothing is driven.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lb_cyc_q   <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_adr_q   <= '0;
            lb_sel_q   <= 4'b0000;
            lb_dat_w_q <= 32'h0;
            ad_out_q   <= 32'h0;
            ad_oe_q    <= 1'b0;
            tm_out_q   <= 2'b00;
            ack_out_q  <= 1'b0;
            resp_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lb_cyc_q   <= lb_cyc_d;
            lb_we_q    <= lb_we_d;
            lb_adr_q   <= lb_adr_d;
            lb_sel_q   <= lb_sel_d;
            lb_dat_w_q <= lb_dat_w_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            tm_out_q   <= tm_out_d;
            ack_out_q  <= ack_out_d;
            resp_oe_q  <= resp_oe_d;
        end
    end

    assign lb_cyc   = lb_cyc_q;
    assign lb_we    = lb_we_q;
    assign lb_adr   = lb_adr_q;
    assign lb_sel   = lb_sel_q;
    assign lb_dat_w = lb_dat_w_q;
    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign tm_out   = tm_out_q;
    assign ack_out  = ack_out_q;
    assign resp_oe  = resp_oe_q;

endmodule

// File: tb/tb_nubus_slave_responder.sv
// Directed bench for nubus_slave_responder with a cycle-indexed expected-trace model.
module tb_nubus_slave_responder;

    localparam int TO = 200;
    localparam int N  = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  slot_id = 4'hC;
    logic        start = 1'b0;
    logic        ack_in = 1'b0;
    logic [31:0] ad_in = 32'h0;
    logic [1:0]  tm_in = 2'b00;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic [1:0]  tm_out;
    logic        ack_out;
    logic        resp_oe;
    logic        lb_cyc;
    logic        lb_we;
    logic [21:0] lb_adr;
    logic [3:0]  lb_sel;
    logic [31:0] lb_dat_w;
    logic [31:0] lb_dat_r = 32'h0;
    logic        lb_ack = 1'b0;
    logic        lb_err = 1'b0;

    nubus_slave_responder #(.TIMEOUT_CYCLES(TO), .LB_ADDR_W(22)) dut (
        .sys_clk (clk),     .sys_rst (rst),     .slot_id (slot_id),
        .start   (start),   .ack_in  (ack_in),  .ad_in   (ad_in),
        .tm_in   (tm_in),   .ad_out  (ad_out),  .ad_oe   (ad_oe),
        .tm_out  (tm_out),  .ack_out (ack_out), .resp_oe (resp_oe),
        .lb_cyc  (lb_cyc),  .lb_we   (lb_we),   .lb_adr  (lb_adr),
        .lb_sel  (lb_sel),  .lb_dat_w(lb_dat_w),.lb_dat_r(lb_dat_r),
        .lb_ack  (lb_ack),  .lb_err  (lb_err)
    );

    always #5 clk = ~clk;

    // cyc == k during the clock period that follows rising edge k
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int cyc_high = 0;

    // Expected trace, indexed by clock period
    bit          exp_cyc  [N];
    bit          exp_we   [N];
    logic [21:0] exp_adr  [N];
    logic [3:0]  exp_sel  [N];
    logic [31:0] exp_dat  [N];
    bit          exp_resp [N];
    logic [1:0]  exp_tm   [N];
    bit          exp_adoe [N];
    logic [31:0] exp_adout[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: which periods carry a local request and which one carries the ACK.
    // kind: 0 = lb_ack, 1 = lb_err, 2 = both together, 3 = never answered
    task automatic model(input int t, input logic [1:0] tm, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int w, input int kind);
        bit         we;
        logic [3:0] sel;
        int         s, n, r;
        logic [1:0] st;
        we = tm[1];
        if (tm[0] && addr[1:0] == 2'b11)      sel = 4'hF;
        else if (tm[0] && addr[1:0] == 2'b00) sel = 4'b0011;
        else if (tm[0] && addr[1:0] == 2'b10) sel = 4'b1100;
        else if (!tm[0])                      sel = 4'b0001 << addr[1:0];
        else                                  sel = 4'b0000;
        if (sel == 4'b0000) begin
            exp_resp[t] = 1'b1;
            exp_tm[t]   = 2'b01;
            return;
        end
        s = we ? t + 1 : t;
        n = (kind == 3) ? TO : w + 1;
        for (int i = s; i < s + n; i++) begin
            exp_cyc[i] = 1'b1;
            exp_we[i]  = we;
            exp_adr[i] = addr[23:2];
            exp_sel[i] = sel;
            exp_dat[i] = wd;
        end
        r  = s + n;
        st = (kind == 0) ? 2'b00 : (kind == 3) ? 2'b10 : 2'b01;
        exp_resp[r] = 1'b1;
        exp_tm[r]   = st;
        if (!we && kind == 0) begin
            exp_adoe[r] = 1'b1;
            for (int i = r; i < N; i++) exp_adout[i] = rd;
        end
    endtask

    // Per-period comparison of the DUT against the expected trace
    always @(negedge clk) begin
        if (cyc < N) begin
            chk("lb_cyc", {31'b0, lb_cyc}, {31'b0, exp_cyc[cyc]});
            chk("resp_oe", {31'b0, resp_oe}, {31'b0, exp_resp[cyc]});
            chk("ack_out", {31'b0, ack_out}, {31'b0, exp_resp[cyc]});
            chk("ad_oe", {31'b0, ad_oe}, {31'b0, exp_adoe[cyc]});
            chk("ad_out", ad_out, exp_adout[cyc]);
            if (exp_resp[cyc]) chk("tm_out", {30'b0, tm_out}, {30'b0, exp_tm[cyc]});
            if (exp_cyc[cyc]) begin
                chk("lb_we", {31'b0, lb_we}, {31'b0, exp_we[cyc]});
                chk("lb_adr", {10'b0, lb_adr}, {10'b0, exp_adr[cyc]});
                chk("lb_sel", {28'b0, lb_sel}, {28'b0, exp_sel[cyc]});
                if (exp_we[cyc]) chk("lb_dat_w", lb_dat_w, exp_dat[cyc]);
            end
            if (lb_cyc) cyc_high++;
        end
    end

    // One NuBus transaction plus the matching local-bus reply timing
    task automatic xact(input logic [1:0] tm, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int w, input int kind, input bit inj);
        int t, s;
        @(posedge clk); #1;
        start = 1'b1; ad_in = addr; tm_in = tm;
        t = cyc + 1;
        model(t, tm, addr, wd, rd, w, kind);
        @(posedge clk); #1;
        start = 1'b0; ad_in = wd; tm_in = 2'b00;
        if (inj) begin
            start = 1'b1; ad_in = 32'hFC000013;
        end
        s = tm[1] ? t + 1 : t;
        if (!(tm[0] && addr[1:0] == 2'b01)) begin
            if (kind == 3) begin
                while (cyc < s + TO + 1) begin @(posedge clk); #1; start = 1'b0; end
            end else begin
                while (cyc < s + w) begin @(posedge clk); #1; start = 1'b0; end
                lb_dat_r = rd;
                lb_ack = (kind != 1);
                lb_err = (kind != 0);
                @(posedge clk); #1;
                lb_ack = 1'b0; lb_err = 1'b0; start = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int t, base;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ack_out", {31'b0, ack_out}, 32'h0);
        chk("rst lb_cyc", {31'b0, lb_cyc}, 32'h0);
        chk("rst ad_out", ad_out, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // slot C word write, zero wait
        xact(2'b11, 32'hFC000003, 32'h87654321, 32'h0, 0, 0, 1'b0);
        chk("pin wr adr", {10'b0, lb_adr}, 32'h0);
        chk("pin wr sel", {28'b0, lb_sel}, 32'hF);
        chk("pin wr dat", lb_dat_w, 32'h87654321);
        // word read, three wait cycles, with an illegal START during ACCESS
        xact(2'b01, 32'hFC000007, 32'hDEADBEEF, 32'hC0FFEE00, 3, 0, 1'b1);
        chk("pin rd ad_out", ad_out, 32'hC0FFEE00);
        // byte2 write, half1 write, byte1 read
        xact(2'b10, 32'hFC00000E, 32'h00AA0000, 32'h0, 0, 0, 1'b0);
        chk("pin byte2 sel", {28'b0, lb_sel}, 32'h4);
        chk("pin byte2 adr", {10'b0, lb_adr}, 32'h3);
        xact(2'b11, 32'hFC000012, 32'hBBBB0000, 32'h0, 1, 0, 1'b0);
        chk("pin half1 sel", {28'b0, lb_sel}, 32'hC);
        xact(2'b00, 32'hFC000015, 32'h0, 32'h12345678, 1, 0, 1'b0);
        chk("pin byte1 sel", {28'b0, lb_sel}, 32'h2);
        // block mode, local error, ack+err together
        xact(2'b01, 32'hFC000019, 32'h0, 32'h0, 0, 0, 1'b0);
        xact(2'b01, 32'hFC000023, 32'h0, 32'h55555555, 0, 1, 1'b0);
        xact(2'b01, 32'hFC000027, 32'h0, 32'h66666666, 2, 2, 1'b0);
        chk("pin err hold", ad_out, 32'h12345678);
        // timeout
        base = cyc_high;
        xact(2'b01, 32'hFC00002B, 32'h0, 32'h0, 0, 3, 1'b0);
        chk("pin timeout len", cyc_high - base, TO);

        // non-matching slot and attention cycle
        @(posedge clk); #1;
        start = 1'b1; ad_in = 32'hFB000003; tm_in = 2'b01;
        @(posedge clk); #1;
        ad_in = 32'hFC000003; ack_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ack_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // reset during ACCESS
        start = 1'b1; ad_in = 32'hFC000020; tm_in = 2'b00;
        t = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = t; i < t + 5; i++) begin
            exp_cyc[i] = 1'b1; exp_we[i] = 1'b0; exp_adr[i] = 22'h8; exp_sel[i] = 4'b0001;
        end
        for (int i = t + 5; i < N; i++) exp_adout[i] = 32'h0;
        while (cyc < t + 5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("mid rst lb_cyc", {31'b0, lb_cyc}, 32'h0);
        chk("mid rst resp_oe", {31'b0, resp_oe}, 32'h0);
        chk("mid rst ad_out", ad_out, 32'h0);
        chk("mid rst lb_adr", {10'b0, lb_adr}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xact(2'b01, 32'hFC00003F, 32'h0, 32'hA5A5A5A5, 0, 0, 1'b0);
        chk("pin retry ad_out", ad_out, 32'hA5A5A5A5);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nubus_slave_responder.md
Name: nubus_slave_responder

Overview:
Card-side NuBus slave transaction engine: detects START cycles addressed to this card's slot space, decodes transfer mode and byte lanes, and runs one local-bus access per NuBus cycle. It then answers with a single-cycle ACK carrying a status code and, for reads, the data. It sits between the CPLD/level-shifter interface (asserted-high, already-inverted NuBus signals) and the card's internal memory/register fabric. It is the responder to the virtual NuBus master used in the slave bench.

Parameters:
TIMEOUT_CYCLES, 200, local-bus wait limit in sys_clk cycles before answering with timeout status (must be < 255, the NuBus bus timeout).
LB_ADDR_W, 22, local word-address width (slot offset AD[23:2]).

Ports:
sys_clk  in  1  NuBus clock, inverted; rising edge = NuBus sampling edge
sys_rst  in  1  asynchronous, active-high reset
slot_id  in  4  card slot ID, asserted-high
start  in  1  NuBus START, asserted-high
ack_in  in  1  NuBus ACK as seen on bus, asserted-high
ad_in  in  32  NuBus AD, asserted-high
tm_in  in  2  NuBus {TM1,TM0}, asserted-high
ad_out  out  32  read data to bus
ad_oe  out  1  drive AD
tm_out  out  2  status code on {TM1,TM0}
ack_out  out  1  ACK value
resp_oe  out  1  drive ACK/TM
lb_cyc  out  1  local request valid
lb_we  out  1  local write
lb_adr  out  LB_ADDR_W  local word address
lb_sel  out  4  byte enables, bit n = AD[8n+7:8n]
lb_dat_w  out  32  write data
lb_dat_r  in  32  read data
lb_ack  in  1  local completion
lb_err  in  1  local error

Behaviour:
- Reset: all outputs 0; FSM in IDLE; timeout counter 0. Reset mid-transaction aborts immediately: lb_cyc drops, nothing is driven. A master retry after reset is served normally.
- Address match: start=1 & ack_in=0 & ad_in[31:28]==4'hF & ad_in[27:24]==slot_id. start=1 with ack_in=1 (attention cycle) is ignored. A non-matching START is ignored.
- Mode decode at START: tm_in[1]=1 means write, 0 means read. {tm_in[0], ad_in[1:0]} selects the size:
  - 000 byte0, 001 byte1, 010 byte2, 011 byte3
  - 100 half0 (sel 0011), 110 half1 (sel 1100), 111 word (sel 1111)
  - 101 block: unsupported.
- Status codes {TM1,TM0} asserted-high: COMPLETE=00, ERROR=01, TIMEOUT=10, TRY_AGAIN_LATER=11.
- FSM states: IDLE, WDATA, ACCESS, RESPOND.
  - IDLE→WDATA: matched write. Latch lb_adr=ad_in[23:2], lb_sel, lb_we=1.
  - IDLE→ACCESS: matched read. Latch the same fields, lb_we=0.
  - IDLE→RESPOND: matched block mode, status ERROR, no local access.
  - WDATA (START cycle + 1): capture lb_dat_w=ad_in, then go to ACCESS.
  - ACCESS: lb_cyc=1; lb_adr/lb_sel/lb_we/lb_dat_w stay stable.
    - lb_ack → RESPOND with COMPLETE; for reads, latch lb_dat_r into ad_out.
    - lb_err → RESPOND with ERROR. lb_err wins if both arrive together.
    - Counter reaches TIMEOUT_CYCLES → drop lb_cyc, RESPOND with TIMEOUT.
    - lb_cyc drops in the cycle after the response is sampled.
  - RESPOND: exactly one cycle with resp_oe=1, ack_out=1, tm_out=status. ad_oe=1 only for reads with COMPLETE status. Then go to IDLE; the counter clears.
- Latency with zero-wait local bus (lb_ack in the first lb_cyc cycle), START sampled at T:
  - read: lb_cyc at T+1, ACK at T+2
  - write: lb_cyc at T+2, ACK at T+3
- A START arriving in any non-IDLE state is ignored (illegal on NuBus). A matched START in the RESPOND cycle is not accepted; IDLE is entered first.
- ad_out holds its last value when ad_oe=0.

Decomposition:
- Package nubus_pkg holds:
  - FSM state enum
  - status constants ST_COMPLETE/ST_ERROR/ST_TIMEOUT/ST_TRY_AGAIN
  - size-code constants SZ_BYTE0..SZ_WORD, SZ_BLOCK
  - function sel_from_size(code)→[3:0]
- One sub-module, nubus_mode_decode: combinational {tm_in, ad_in[1:0]} → we, sel, is_block.

Test Plan:
- Slot C word write: START with addr FC000000, tm write/word, data 87654321, lb_ack on first cycle → lb_cyc at T+2 with adr 000000, sel 1111, dat 87654321; ACK at T+3 with status 00.
- Word read: addr FC000004, lb_dat_r=C0FFEE00 with lb_ack after 3 wait cycles → ad_out=C0FFEE00, ad_oe=1, ACK with 00 one cycle after lb_ack.
- Byte/half lanes: write byte2 at FC00000C → sel 0100; half1 → sel 1100; read byte1 → sel 0010.
- Errors:
  - block-mode START → ACK at T+1, status 01, lb_cyc never asserted
  - lb_err=1 → status 01, ad_oe=0
  - lb_ack and lb_err together → status 01
- Timeout: lb_ack never returned → lb_cyc high exactly TIMEOUT_CYCLES (200) cycles, then ACK with status 10.
- Filtering and reset:
  - START to FB000000, or START with ack_in=1 → no response
  - sys_rst pulsed during ACCESS → all outputs 0 immediately; the next read completes normally.
